// File: rtl/wrr_pkt_arbiter.sv
// Packet-level round-robin arbiter: one-cycle grant pulse per packet, one-hot select held until end of packet.
// Latency: 1 cycle from request to grant; one IDLE cycle after every iDone (max one grant per 2 cycles).
// Backpressure: iReq is ignored while a packet is outstanding; optional grant watchdog via WRR_ARB_WATCHDOG_EN.
module wrr_pkt_arbiter #(
    parameter int ARB_NUM     = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic [ARB_NUM-1:0]         iReq,
    output logic [ARB_NUM-1:0]         oGnt,
    output logic [ARB_NUM-1:0]         oSel,
    output logic [$clog2(ARB_NUM)-1:0] oSelIdx,
    output logic                       oBusy,
    input  logic                       iDone,
    output logic                       oTimeout
);

    localparam int IDX_W = $clog2(ARB_NUM);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (ARB_NUM < 2) begin : g_bad_arb_num
        $error("wrr_pkt_arbiter: ARB_NUM must be >= 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("wrr_pkt_arbiter: TIMEOUT_CYC must be >= 2");
    end

    logic [0:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [IDX_W:0]     pos;
    logic [ARB_NUM-1:0] win_oh;
    logic               expire;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        pos     = '0;
        for (int k = ARB_NUM - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(ARB_NUM))
                pos = pos - (IDX_W+1)'(ARB_NUM);
            if (iReq[pos[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = pos[IDX_W-1:0];
            end
        end
    end

    assign win_oh  = {{(ARB_NUM-1){1'b0}}, 1'b1} << win_idx;
    assign ptr_nxt = (oSelIdx == IDX_W'(ARB_NUM - 1)) ? '0 : oSelIdx + 1'b1;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            oGnt    <= '0;
            oSel    <= '0;
            oSelIdx <= '0;
            oBusy   <= 1'b0;
        end else begin
            oGnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state   <= ST_GRANT;
                        oGnt    <= win_oh;
                        oSel    <= win_oh;
                        oSelIdx <= win_idx;
                        oBusy   <= 1'b1;
                    end
                end
                default: begin
                    if (iDone || expire) begin
                        state <= ST_IDLE;
                        oSel  <= '0;
                        oBusy <= 1'b0;
                        ptr   <= ptr_nxt;
                    end
                end
            endcase
        end
    end

`ifdef WRR_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;

    assign expire = (state == ST_GRANT) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // A coincident iDone wins over expiry: normal completion, no timeout pulse.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wd_cnt   <= '0;
            oTimeout <= 1'b0;
        end else begin
            oTimeout <= expire && !iDone;
            if (state != ST_GRANT)
                wd_cnt <= '0;
            else if (!iDone)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign expire   = 1'b0;
    assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Self-checking bench for wrr_pkt_arbiter (ARB_NUM=4, TIMEOUT_CYC=8): vector table, corner sequences, random vs model.
module tb_wrr_pkt_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef WRR_ARB_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic         iClk;
    logic         iRst;
    logic [N-1:0] iReq;
    logic [N-1:0] oGnt;
    logic [N-1:0] oSel;
    logic [1:0]   oSelIdx;
    logic         oBusy;
    logic         iDone;
    logic         oTimeout;

    wrr_pkt_arbiter #(.ARB_NUM(N), .TIMEOUT_CYC(TO)) dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .oGnt(oGnt), .oSel(oSel),
        .oSelIdx(oSelIdx), .oBusy(oBusy), .iDone(iDone), .oTimeout(oTimeout)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [3:0] sel;
        logic       busy;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: packet-level view (busy flag, granted queue, rotating start, grant age).
    bit m_busy;
    bit m_gnt;
    bit m_to;
    int m_idx;
    int m_ptr;
    int m_age;

    function automatic logic [3:0] oh(input int q);
        logic [3:0] one;
        one = 4'b0001;
        return one << q;
    endfunction

    function automatic void add(input logic rst, input logic [3:0] req, input logic done,
                                input logic [3:0] gnt, input logic [3:0] sel, input logic busy,
                                input logic [1:0] idx);
        vec_t v;
        v.rst = rst; v.req = req; v.done = done;
        v.gnt = gnt; v.sel = sel; v.busy = busy; v.idx = idx;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic void model_reset();
        m_busy = 0; m_gnt = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_age = 0;
    endfunction

    function automatic void model_step(input logic [3:0] req, input logic done);
        m_gnt = 0;
        m_to  = 0;
        if (!m_busy) begin
            for (int off = 0; off < N; off++) begin
                int q;
                q = (m_ptr + off) % N;
                if (!m_busy && req[q]) begin
                    m_busy = 1; m_gnt = 1; m_idx = q; m_age = 0;
                end
            end
        end else if (done) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % N;
        end else if (WD_ON && m_age == TO - 1) begin
            m_busy = 0;
            m_to   = 1;
            m_ptr  = (m_idx + 1) % N;
        end else begin
            m_age++;
        end
    endfunction

    initial begin
        iRst = 1'b1; iReq = '0; iDone = 1'b0;

        // Held 1111, iDone in the 3rd GRANT cycle: order 0,1,2,3,0.
        add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
        for (int p = 0; p < 5; p++) begin
            add(0, 4'b1111, 0, oh(p % N), oh(p % N), 1, 2'(p % N));
            add(0, 4'b1111, 0, 4'b0000,   oh(p % N), 1, 2'(p % N));
            add(0, 4'b1111, 0, 4'b0000,   oh(p % N), 1, 2'(p % N));
            add(0, 4'b1111, 1, 4'b0000,   4'b0000,   0, 2'(p % N));
        end
        // Sparse 1010 with single-cycle packets, idle iDone, dropped request, pointer wrap.
        add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd0);
        add(0, 4'b1010, 0, 4'b0010, 4'b0010, 1, 2'd1);
        add(0, 4'b1010, 1, 4'b0000, 4'b0000, 0, 2'd1);
        add(0, 4'b1010, 0, 4'b1000, 4'b1000, 1, 2'd3);
        add(0, 4'b1010, 1, 4'b0000, 4'b0000, 0, 2'd3);
        add(0, 4'b1010, 0, 4'b0010, 4'b0010, 1, 2'd1);
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd1);
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd1);
        add(0, 4'b0100, 0, 4'b0100, 4'b0100, 1, 2'd2);
        for (int c = 0; c < 5; c++)
            add(0, 4'b0000, 0, 4'b0000, 4'b0100, 1, 2'd2);
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd2);
        add(0, 4'b1111, 0, 4'b1000, 4'b1000, 1, 2'd3);
        add(0, 4'b1111, 1, 4'b0000, 4'b0000, 0, 2'd3);
        add(0, 4'b1111, 0, 4'b0001, 4'b0001, 1, 2'd0);
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            iRst  = vecs[i].rst;
            iReq  = vecs[i].req;
            iDone = vecs[i].done;
            tick();
            check($sformatf("vec%0d gnt/sel/busy/idx/to", i),
                  32'({oGnt, oSel, oBusy, oSelIdx, oTimeout}),
                  32'({vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].idx, 1'b0}));
        end

        // Asynchronous reset mid-GRANT with a nonzero pointer.
        iRst = 1'b1; tick(); iRst = 1'b0;
        iReq = 4'b0010; tick();
        iDone = 1'b1; tick(); iDone = 1'b0;
        iReq = 4'b0100; tick();
        check("pre_reset_sel", 32'(oSel), 32'(4'b0100));
        iRst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({oGnt, oSel, oBusy, oSelIdx}), 32'(0));
        tick();
        iRst = 1'b0; iReq = 4'b1111; tick();
        check("post_reset_ptr0_gnt", 32'(oGnt), 32'(4'b0001));
        iReq = 4'b1000; iDone = 1'b1; tick(); iDone = 1'b0;
        tick();
        check("post_reset_req1000_gnt", 32'(oGnt), 32'(4'b1000));
        iDone = 1'b1; tick(); iDone = 1'b0;

        // Grant queue 1 and never complete it: watchdog abort or indefinite hold.
        iRst = 1'b1; tick(); iRst = 1'b0;
        iReq = 4'b0010; tick();
        check("wd_first_gnt", 32'(oGnt), 32'(4'b0010));
        iReq = 4'b0000;
        for (int c = 1; c <= 20; c++) begin
            logic [3:0] exp_sel;
            logic       exp_to;
            tick();
            exp_sel = (WD_ON && c >= TO) ? 4'b0000 : 4'b0010;
            exp_to  = WD_ON && (c == TO);
            check($sformatf("hold_c%0d sel/to", c), 32'({oSel, oTimeout}), 32'({exp_sel, exp_to}));
        end
        iDone = 1'b1; tick(); iDone = 1'b0;
        iReq = 4'b1111; tick();
        check("after_hold_ptr2_gnt", 32'(oGnt), 32'(4'b0100));
        iDone = 1'b1; tick(); iDone = 1'b0;

        // Random traffic against the model, with occasional async resets.
        iRst = 1'b1; tick(); iRst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] req;
            logic       done;
            logic       rst;
            rst  = ($urandom_range(0, 199) == 0);
            req  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0);
            iRst = rst; iReq = req; iDone = done;
            if (rst) model_reset();
            else     model_step(req, done);
            tick();
            check($sformatf("rand_c%0d", c),
                  32'({oGnt, oSel, oBusy, oSelIdx, oTimeout}),
                  32'({(m_gnt ? oh(m_idx) : 4'b0000), (m_busy ? oh(m_idx) : 4'b0000),
                       m_busy, 2'(m_idx), m_to}));
            if (oGnt != 0 && oGnt != oSel)
                check($sformatf("rand_inv_c%0d gnt_eq_sel", c), 32'(oGnt), 32'(oSel));
        end
        iRst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wrr_pkt_arbiter.md
Name: wrr_pkt_arbiter

Overview:
Packet-level round-robin arbiter that sits directly downstream of the per-queue WRR weight gate in the read-control path. It consumes the gated request vector and issues a one-cycle grant pulse per packet, which the weight gate uses to decrement its weight. It holds a one-hot queue select until the read datapath signals end of packet, then advances its rotating priority pointer.

Parameters:
ARB_NUM, 8, number of requesting queues (>=2).
TIMEOUT_CYC, 1024, grant watchdog limit in cycles; used only with the optional feature.

Ports:
iClk  input  1  clock.
iRst  input  1  reset, asynchronous, active-high.
iReq  input  ARB_NUM  gated requests from the weight gate, one bit per queue.
oGnt  output  ARB_NUM  one-hot grant pulse, high for exactly one cycle per packet; returned to the weight gate.
oSel  output  ARB_NUM  one-hot selected queue, held for the whole packet.
oSelIdx  output  $clog2(ARB_NUM)  binary index of the selected queue, valid while oBusy.
oBusy  output  1  high while a packet grant is outstanding.
iDone  input  1  end-of-packet strobe from the read datapath for the selected queue.
oTimeout  output  1  one-cycle pulse on watchdog abort; tied 0 when the feature is excluded.

Behaviour:
- Single clock domain: iClk. Reset is asynchronous and active-high (iRst).
- Reset values:
  - oGnt=0, oSel=0, oSelIdx=0, oBusy=0, oTimeout=0.
  - Internal: state=IDLE, ptr=0, watchdog count=0.
  - Reset takes effect immediately, including mid-packet. No partial grant survives reset.
- State machine with two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - Each cycle, winner = first set bit of iReq searched cyclically from index ptr upward, wrapping ARB_NUM-1 to 0.
  - If iReq==0, stay in IDLE; outputs remain 0.
  - If iReq!=0, at the next edge: state<=GRANT, oGnt<=onehot(winner), oSel<=onehot(winner), oSelIdx<=winner, oBusy<=1.
  - Latency from request to grant is 1 cycle.
- GRANT:
  - oGnt<=0 at every edge, so the pulse lasts exactly one cycle (the first GRANT cycle).
  - iReq is ignored. A requester dropping its request does not revoke oSel.
  - If iDone=1 (including in the first GRANT cycle, which supports single-cycle packets), at the next edge: state<=IDLE, oSel<=0, oBusy<=0, ptr<=(oSelIdx+1) mod ARB_NUM. oSelIdx keeps its last value.
  - If iDone=0, hold all outputs.
- iDone is ignored in IDLE.
- Inter-packet gap:
  - Exactly one IDLE cycle follows each iDone.
  - This guarantees the weight gate's decrement and any weight refresh are visible in iReq before re-arbitration.
  - Maximum throughput is one grant per 2 cycles.
- Pointer wrap: ptr is a counter of width $clog2(ARB_NUM) with explicit wrap at ARB_NUM, so non-power-of-2 ARB_NUM is correct.
- Invariants:
  - oGnt and oSel are always zero or one-hot.
  - oGnt is nonzero only when oSel equals oGnt.
  - oBusy == (oSel != 0).

Optional Feature:
Macro: WRR_ARB_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to GRANT and increments each GRANT cycle without iDone.
  - When it reaches TIMEOUT_CYC-1 with iDone=0, at the next edge: abort to IDLE, oSel<=0, oBusy<=0, ptr advances as for iDone, oTimeout pulses for 1 cycle.
  - iDone in the same cycle as expiry counts as normal completion; oTimeout stays 0.
- Not defined: no counter is implemented, oTimeout is constant 0, and a grant is held indefinitely until iDone.

Test Plan:
- ARB_NUM=4, reset then iReq=4'b1111 held, iDone pulsed in the 3rd GRANT cycle each packet: grant order is 0,1,2,3,0. Each oGnt is exactly 1 cycle. oSel is held for 3 cycles, followed by 1 IDLE cycle.
- iReq=4'b1010 from reset: first grant is 4'b0010. After iDone, ptr=2 and the next grant is 4'b1000. After that ptr=0 and the grant is 4'b0010.
- iDone asserted in the same cycle as the oGnt pulse: oSel clears at the next edge, one IDLE cycle follows, and the next oGnt comes on the following edge. ptr advances correctly.
- Queue 2 granted (oSel=4'b0100), then iReq[2] dropped for 5 cycles before iDone: oSel stays 4'b0100, no second oGnt, and oBusy holds until iDone.
- iRst asserted mid-GRANT with no clock edge: oGnt, oSel and oBusy go to 0 asynchronously. After release with iReq=4'b1000, ptr=0 and the grant is 4'b1000.
- With WRR_ARB_WATCHDOG_EN and TIMEOUT_CYC=8: grant queue 1 with no iDone. oTimeout pulses and oSel clears 8 cycles after the oGnt cycle. The next grant search starts at ptr=2. With the macro undefined, oSel is still held after 20 cycles.
